// File: rtl/apb_pattern_master.sv
// apb_pattern_master: APB initiator that fills the HUB75 frame buffer with a test pattern, programs the row width, then reads STATUS.
//   pclk/presetn      clock, async active-low reset
//   start             one-cycle run request, accepted when idle
//   pattern           0 solid, 1 color bars, 2 gradient, 3 checkerboard
//   fill_color        {B,G,R} for solid fill
//   busy/done         run in progress / one-cycle end-of-run pulse
//   status_ok         STATUS read returned 32'hDEADBEEF
//   psel..pwdata      APB request, pready/prdata APB response
module apb_pattern_master #(
  parameter int ROWS = 32,
  parameter int COLS = 64
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        start,
  input  logic [1:0]  pattern,
  input  logic [23:0] fill_color,
  output logic        busy,
  output logic        done,
  output logic        status_ok,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [17:0] paddr,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic [31:0] prdata
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  typedef enum logic [1:0] {FILL, CFG, CHK} phase_t;
  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);
  localparam logic [8:0] COL_LAST = 9'(COLS - 1);
  state_t state, state_nx;
  phase_t phase;
  logic [5:0] row;
  logic [8:0] col;
  logic [1:0] pat_q;
  logic [23:0] color_q;
  logic [2:0] bar;
  logic [31:0] pix;
  logic xfer_done;
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) state <= IDLE;
    else state <= state_nx;
  // Address/data come straight from the counters, which only move at the end
  // of an ACCESS, so they stay stable from SETUP through every wait state.
  always_comb begin
    xfer_done = state == ACCESS && pready;
    state_nx = state == IDLE ? (start ? SETUP : IDLE) :
               state == SETUP ? ACCESS :
               pready ? (phase == CHK ? IDLE : SETUP) : ACCESS;
    psel = state != IDLE;
    penable = state == ACCESS;
    busy = psel;
    pwrite = psel && phase != CHK;
    bar = col[5:3];
    pix = pat_q == 2'd0 ? {8'h00, color_q} :
          pat_q == 2'd1 ? {8'h00, {8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} :
          pat_q == 2'd2 ? {16'h0000, row, 2'b00, col[5:0], 2'b00} :
          (row[3] ^ col[3]) ? 32'h00FF_FFFF : 32'h0;
    paddr = !psel ? 18'h0 : phase == FILL ? {1'b0, row, col, 2'b00} :
            phase == CFG ? 18'h20008 : 18'h20000;
    pwdata = !psel ? 32'h0 : phase == FILL ? pix : phase == CFG ? 32'(COLS) : 32'h0;
  end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      row <= '0;
      col <= '0;
      phase <= FILL;
      pat_q <= '0;
      color_q <= '0;
      done <= 1'b0;
      status_ok <= 1'b0;
    end else begin
      done <= xfer_done && phase == CHK;
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
        phase <= FILL;
        pat_q <= pattern;
        color_q <= fill_color;
        status_ok <= 1'b0;
      end else if (xfer_done) begin
        if (phase == FILL) begin
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) phase <= CFG;
            else row <= row + 6'd1;
          end else col <= col + 9'd1;
        end else if (phase == CFG) phase <= CHK;
        else status_ok <= prdata == 32'hDEADBEEF;
      end
    end
endmodule

// File: tb/tb_apb_pattern_master.sv
// tb_apb_pattern_master: randomized and directed checks of apb_pattern_master against a transfer-list model.
module tb_apb_pattern_master;
  logic pclk = 0, presetn = 0, start = 0, pready = 0;
  logic [1:0] pattern = 0;
  logic [23:0] fill_color = 0;
  logic [31:0] prdata = 0;
  logic start_v[3], busy_v[3], done_v[3], ok_v[3], psel_v[3], pen_v[3], pwr_v[3];
  logic [17:0] paddr_v[3];
  logic [31:0] pwdata_v[3];
  int sel = 0;
  int rows_v[3] = '{2, 1, 10};
  int cols_v[3] = '{4, 64, 12};
  int n_chk = 0, n_pass = 0;
  logic [17:0] obs_a[$];
  logic [31:0] obs_d[$];
  logic o_psel, o_pen, o_pwr, o_busy, o_done, o_ok;
  logic [17:0] o_paddr;
  logic [31:0] o_pwdata;

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign start_v[g] = start && sel == g;
    apb_pattern_master #(.ROWS(g == 0 ? 2 : g == 1 ? 1 : 10), .COLS(g == 0 ? 4 : g == 1 ? 64 : 12)) dut (
      .pclk(pclk), .presetn(presetn), .start(start_v[g]), .pattern(pattern), .fill_color(fill_color),
      .busy(busy_v[g]), .done(done_v[g]), .status_ok(ok_v[g]), .psel(psel_v[g]), .penable(pen_v[g]),
      .pwrite(pwr_v[g]), .paddr(paddr_v[g]), .pwdata(pwdata_v[g]), .pready(pready), .prdata(prdata));
  end

  assign o_psel = psel_v[sel];
  assign o_pen = pen_v[sel];
  assign o_pwr = pwr_v[sel];
  assign o_busy = busy_v[sel];
  assign o_done = done_v[sel];
  assign o_ok = ok_v[sel];
  assign o_paddr = paddr_v[sel];
  assign o_pwdata = pwdata_v[sel];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (dut %0d, t=%0t)", nm, got, exp, sel, $time);
  endtask

  // Transfer k of a run, derived from pixel coordinates with plain arithmetic.
  function automatic void model(input int s, input int k, input logic [1:0] p, input logic [23:0] c,
                                output logic [17:0] a, output bit w, output logic [31:0] d);
    int r, cc, bar, nr, nc;
    nr = rows_v[s];
    nc = cols_v[s];
    w = 1;
    d = 0;
    if (k < nr * nc) begin
      r = k / nc;
      cc = k % nc;
      a = 18'(r * 2048 + cc * 4);
      bar = (cc / 8) % 8;
      case (p)
        2'd0: d = {8'h00, c};
        2'd1: d = ((bar % 2) != 0 ? 32'hFF : 0) + ((bar / 2) % 2 != 0 ? 32'hFF00 : 0) + ((bar / 4) % 2 != 0 ? 32'hFF0000 : 0);
        2'd2: d = 32'(((r % 64) * 4) * 256 + (cc % 64) * 4);
        default: d = ((r / 8) % 2) != ((cc / 8) % 2) ? 32'h00FFFFFF : 32'h0;
      endcase
    end else if (k == nr * nc) begin
      a = 18'h20008;
      d = 32'(nc);
    end else begin
      a = 18'h20000;
      w = 0;
    end
  endfunction

  task automatic bus(input string ph, input bit en, input logic [17:0] a, input bit w, input logic [31:0] d);
    chk({ph, "_psel"}, o_psel, 1);
    chk({ph, "_penable"}, o_pen, en);
    chk({ph, "_paddr"}, o_paddr, a);
    chk({ph, "_pwrite"}, o_pwr, w);
    if (w) chk({ph, "_pwdata"}, o_pwdata, d);
    chk({ph, "_busy"}, o_busy, 1);
    chk({ph, "_done"}, o_done, 0);
  endtask

  task automatic run(input int s, input logic [1:0] pat, input logic [23:0] col, input bit ok,
                     input int wk, input int wn, input bit rnd, input int abort_k, input int mid_k,
                     output int done_cyc);
    int n, cyc, waits, w;
    logic [17:0] a;
    bit wr;
    logic [31:0] d;
    n = rows_v[s] * cols_v[s] + 2;
    done_cyc = -1;
    sel = s;
    obs_a.delete();
    obs_d.delete();
    @(negedge pclk);
    chk("idle_busy", o_busy, 0);
    chk("idle_psel", o_psel, 0);
    pattern = pat;
    fill_color = col;
    start = 1;
    cyc = 0;
    waits = 0;
    @(negedge pclk);
    start = 0;
    cyc = 1;
    for (int k = 0; k < n; k++) begin
      model(s, k, pat, col, a, wr, d);
      bus("setup", 0, a, wr, d);
      obs_a.push_back(o_paddr);
      obs_d.push_back(o_pwdata);
      if (k == abort_k) begin
        #2 presetn = 0;
        #1;
        chk("abort_psel", o_psel, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_penable", o_pen, 0);
        @(negedge pclk);
        chk("abort_done", o_done, 0);
        presetn = 1;
        @(negedge pclk);
        chk("abort_after_psel", o_psel, 0);
        chk("abort_after_done", o_done, 0);
        chk("abort_after_busy", o_busy, 0);
        return;
      end
      if (k == mid_k) begin
        start = 1;
        pattern = ~pat;
        fill_color = ~col;
      end
      pready = 1'($urandom);
      prdata = $urandom;
      @(negedge pclk);
      cyc++;
      start = 0;
      w = (k == wk) ? wn : (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      waits += w;
      for (int j = 0; j <= w; j++) begin
        bus("access", 1, a, wr, d);
        pready = (j == w);
        prdata = $urandom;
        if (k == n - 1 && j == w)
          prdata = ok ? 32'hDEADBEEF : ($urandom_range(0, 1) != 0 ? 32'h0 : 32'hDEADBEEF ^ (32'h1 << $urandom_range(0, 31)));
        @(negedge pclk);
        cyc++;
      end
    end
    chk("end_cycle", 32'(cyc), 32'(2 * n + 1 + waits));
    chk("end_done", o_done, 1);
    chk("end_busy", o_busy, 0);
    chk("end_psel", o_psel, 0);
    chk("end_status_ok", o_ok, ok);
    done_cyc = o_done ? cyc : -1;
    pready = 1'($urandom);
    @(negedge pclk);
    chk("post_done", o_done, 0);
    chk("post_psel", o_psel, 0);
    chk("post_status_hold", o_ok, ok);
  endtask

  initial begin
    int dc;
    logic [17:0] exp_a[10];
    exp_a = '{18'h00000, 18'h00004, 18'h00008, 18'h0000C, 18'h00800, 18'h00804, 18'h00808, 18'h0080C, 18'h20008, 18'h20000};
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      start = ~start;
      pready = ~pready;
      prdata = $urandom;
      for (int g = 0; g < 3; g++) begin
        sel = g;
        #1;
        chk("rst_psel", o_psel, 0);
        chk("rst_penable", o_pen, 0);
        chk("rst_pwrite", o_pwr, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_status_ok", o_ok, 0);
        chk("rst_paddr", o_paddr, 0);
        chk("rst_pwdata", o_pwdata, 0);
      end
    end
    start = 0;
    sel = 0;
    @(negedge pclk);
    presetn = 1;
    repeat (3) begin
      @(negedge pclk);
      chk("rel_psel", o_psel, 0);
      chk("rel_busy", o_busy, 0);
    end

    run(0, 2'd0, 24'h123456, 1, -1, 0, 0, -1, -1, dc);
    chk("solid_done_cycle", 32'(dc), 21);
    chk("solid_count", 32'(obs_a.size()), 10);
    for (int i = 0; i < 10 && i < obs_a.size(); i++) chk("solid_addr_lit", obs_a[i], exp_a[i]);
    for (int i = 0; i < 8 && i < obs_d.size(); i++) chk("solid_data_lit", obs_d[i], 32'h00123456);
    if (obs_d.size() > 8) chk("solid_cfg_lit", obs_d[8], 32'h4);

    run(0, 2'd0, 24'h123456, 1, 2, 3, 0, -1, -1, dc);
    chk("wait_done_cycle", 32'(dc), 24);

    run(1, 2'd1, 24'h0, 1, -1, 0, 0, -1, -1, dc);
    chk("bars_count", 32'(obs_d.size()), 66);
    if (obs_d.size() == 66) begin
      chk("bars_col8", obs_d[8], 32'h000000FF);
      chk("bars_col24", obs_d[24], 32'h0000FFFF);
      chk("bars_col56", obs_d[56], 32'h00FFFFFF);
      chk("bars_cfg", obs_d[64], 32'h40);
    end

    run(0, 2'd2, 24'h0, 0, -1, 0, 0, -1, -1, dc);
    chk("mismatch_done_cycle", 32'(dc), 21);

    run(0, 2'd0, 24'hA5C3E1, 1, -1, 0, 0, -1, 3, dc);
    chk("midstart_done_cycle", 32'(dc), 21);

    run(0, 2'd0, 24'h123456, 1, -1, 0, 0, 3, -1, dc);
    run(0, 2'd0, 24'h654321, 1, -1, 0, 0, -1, -1, dc);
    if (obs_a.size() > 0) chk("restart_first_addr", obs_a[0], 18'h00000);
    chk("restart_done_cycle", 32'(dc), 21);

    for (int i = 0; i < 12; i++)
      run(int'($urandom_range(0, 2)), 2'($urandom), 24'($urandom), 1'($urandom), -1, 0, 1, -1,
          $urandom_range(0, 3) == 0 ? 1 : -1, dc);
    run(2, 2'd3, 24'h0, 1, 5, 2, 1, -1, -1, dc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
